// File: rtl/cart_mbc1_ctrl.sv
// cart_mbc1_ctrl: MBC1-style bank controller between the Game Boy CPU bus
// and a 256 KB cartridge ROM built from four 64 KB synchronous macros.
// CPU writes to 0x0000-0x7FFF program the bank and mode registers. CPU reads
// become an 18-bit ROM address, and the data returns through a fully
// pipelined path that always takes two cycles.
// Define CART_RAM_EN to add 32 KB of banked cartridge RAM at 0xA000-0xBFFF.
// Without it that window reads UNMAPPED_DATA, and the ram_en register still
// works.

module cart_mbc1_ctrl #(
   parameter int         ROM_BANK_BITS = 4,
   parameter logic [7:0] UNMAPPED_DATA = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   input  logic        cpu_wr,
   input  logic        cpu_rd,
   output logic [7:0]  cpu_dout,
   output logic        cpu_dvalid,
   output logic [17:0] rom_addr,
   input  logic [7:0]  rom_q,
   output logic [4:0]  rom_bank,
   output logic        ram_en,
   output logic        bank_mode
);

   // Where the data for a read comes from. This travels down the pipeline
   // alongside the valid bit.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ROM  = 2'd1,
      SRC_RAM  = 2'd2
   } src_e;

   // Bank numbers are 7 bits wide ({bank_hi, bank_lo}). Only ROM_BANK_BITS of
   // them select real ROM. The rest alias, as on a small MBC1 cartridge.
   localparam int         BANK_MASK_INT = (1 << ROM_BANK_BITS) - 1;
   localparam logic [6:0] BANK_MASK     = 7'(BANK_MASK_INT);

   logic [4:0]  bank_lo;
   logic [1:0]  bank_hi;

   logic        is_rom_win;
   logic        is_ram_win;
   logic        reg_wr;
   logic        rd_accept;

   logic [6:0]  switch_bank;
   logic [6:0]  fixed_bank;
   logic [6:0]  switch_bank_m;
   logic [6:0]  fixed_bank_m;
   logic [20:0] rom_addr_full;

   src_e        rd_src;
   logic        s1_valid;
   src_e        s1_src;
   logic        s2_valid;
   src_e        s2_src;
   logic [7:0]  ram_q;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   assign is_rom_win = ~cpu_addr[15];
   assign is_ram_win = (cpu_addr[15:13] == 3'b101);
   assign reg_wr     = cpu_wr & is_rom_win;
   // When a read and a write arrive together, the write wins and the read
   // never enters the pipeline.
   assign rd_accept  = cpu_rd & ~cpu_wr;

   // ------------------------------------------------------------------
   // Bank arithmetic
   // ------------------------------------------------------------------
   assign switch_bank   = {bank_hi, bank_lo};
   assign fixed_bank    = bank_mode ? {bank_hi, 5'b0_0000} : 7'd0;
   assign switch_bank_m = switch_bank & BANK_MASK;
   assign fixed_bank_m  = fixed_bank & BANK_MASK;
   assign rom_bank      = switch_bank[4:0];

   // The upper 16 KB window uses the switchable bank. The lower window uses
   // the fixed bank.
   assign rom_addr_full = {(cpu_addr[14] ? switch_bank_m : fixed_bank_m),
                           cpu_addr[13:0]};

   // Register writes: RAM enable, bank low, bank high and mode.
   // NOTE: clocked blocks use non-blocking (<=) so every register sees
   // pre-edge values and the update order inside the block does not matter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_lo   <= 5'd1;
         bank_hi   <= 2'd0;
         bank_mode <= 1'b0;
         ram_en    <= 1'b0;
      end else if (reg_wr) begin
         case (cpu_addr[14:13])
            2'd0: ram_en    <= (cpu_din[3:0] == 4'hA);
            2'd1: bank_lo   <= (cpu_din[4:0] == 5'd0) ? 5'd1 : cpu_din[4:0];
            2'd2: bank_hi   <= cpu_din[1:0];
            default: bank_mode <= cpu_din[0];
         endcase
      end
   end

   // Classify the incoming read by the window it targets.
   // NOTE: always_comb assigns a default first so every path drives the
   // output, which keeps synthesis from inferring a latch.
   always_comb begin
      rd_src = SRC_NONE;
      if (is_rom_win) begin
         rd_src = SRC_ROM;
      end
`ifdef CART_RAM_EN
      else if (is_ram_win && ram_en) begin
         rd_src = SRC_RAM;
      end
`endif
   end

   // Stage 1: capture the ROM address and the read source. rom_addr changes
   // only on ROM reads, so the macro address stays stable otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_src   <= SRC_NONE;
         rom_addr <= 18'd0;
      end else begin
         s1_valid <= rd_accept;
         if (rd_accept) begin
            s1_src <= rd_src;
         end
         if (rd_accept && is_rom_win) begin
            rom_addr <= rom_addr_full[17:0];
         end
      end
   end

   // Stage 2: line up valid and source with the data the memory returns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_src   <= SRC_NONE;
      end else begin
         s2_valid <= s1_valid;
         s2_src   <= s1_src;
      end
   end

`ifdef CART_RAM_EN
   // ------------------------------------------------------------------
   // Banked cartridge RAM: 4 x 8 KB. The bank comes from bank_hi only in
   // mode 1.
   // ------------------------------------------------------------------
   logic [7:0]  ram_mem [0:32767];
   logic [1:0]  ram_bank;
   logic [14:0] ram_addr;
   logic [14:0] ram_rd_addr;
   logic        unused_bits;

   assign ram_bank = bank_mode ? bank_hi : 2'd0;
   assign ram_addr = {ram_bank, cpu_addr[12:0]};

   // RAM write port, then a registered read that mirrors the ROM macro.
   // NOTE: the array and its read register have no reset. Clearing a RAM
   // array would prevent it from mapping onto block memory.
   always_ff @(posedge clk) begin
      if (cpu_wr && is_ram_win && ram_en) begin
         ram_mem[ram_addr] <= cpu_din;
      end
      if (rd_accept && is_ram_win) begin
         ram_rd_addr <= ram_addr;
      end
      ram_q <= ram_mem[ram_rd_addr];
   end

   // These bits are intentionally left unconsumed: the address bits above
   // the 18-bit ROM space.
   assign unused_bits = ^{rom_addr_full[20:18]};
`else
   logic unused_bits;

   // Without cartridge RAM the window has no storage and always reads as
   // unmapped.
   assign ram_q       = UNMAPPED_DATA;
   // These bits are intentionally left unconsumed in this build: the address
   // bits above the ROM space, the data bits no register stores, and the RAM
   // window decode.
   assign unused_bits = ^{rom_addr_full[20:18], cpu_din[7:5], is_ram_win};
`endif

   // Output mux: the read result appears during the cycle after stage 2 loads.
   always_comb begin
      cpu_dout = UNMAPPED_DATA;
      if (s2_valid) begin
         case (s2_src)
            SRC_ROM: cpu_dout = rom_q;
            SRC_RAM: cpu_dout = ram_q;
            default: cpu_dout = UNMAPPED_DATA;
         endcase
      end
   end

   assign cpu_dvalid = s2_valid;

endmodule

// File: tb/tb_cart_mbc1_ctrl.sv
// tb_cart_mbc1_ctrl: directed bench for cart_mbc1_ctrl. A behavioural
// 1-cycle ROM returns a data pattern derived from the address. Inputs change
// and outputs are sampled on the falling clock edge.
`timescale 1ns/100ps

module tb_cart_mbc1_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic        cpu_wr;
   logic        cpu_rd;
   logic [7:0]  cpu_dout;
   logic        cpu_dvalid;
   logic [17:0] rom_addr;
   logic [7:0]  rom_q;
   logic [4:0]  rom_bank;
   logic        ram_en;
   logic        bank_mode;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cart_mbc1_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_addr   (cpu_addr),
      .cpu_din    (cpu_din),
      .cpu_wr     (cpu_wr),
      .cpu_rd     (cpu_rd),
      .cpu_dout   (cpu_dout),
      .cpu_dvalid (cpu_dvalid),
      .rom_addr   (rom_addr),
      .rom_q      (rom_q),
      .rom_bank   (rom_bank),
      .ram_en     (ram_en),
      .bank_mode  (bank_mode)
   );

   // ROM content: each byte mixes in the bank and the address bits, so a
   // wrong bank or offset gives a different byte.
   function automatic logic [7:0] rom_byte(input logic [17:0] a);
      return a[7:0] ^ {a[17:14], a[11:8]};
   endfunction

   // Behavioural ROM with a 1-cycle read latency.
   always @(posedge clk) rom_q <= rom_byte(rom_addr);

   // Drives one bus cycle starting at a falling edge and returns at the next
   // falling edge with the strobes released.
   task automatic bus(input logic [15:0] a, input logic [7:0] d,
                      input logic rd, input logic wr);
      cpu_addr = a;
      cpu_din  = d;
      cpu_rd   = rd;
      cpu_wr   = wr;
      @(negedge clk);
      cpu_rd   = 1'b0;
      cpu_wr   = 1'b0;
   endtask

   task automatic test_reset;
      rst      = 1'b1;
      cpu_addr = 16'h0000;
      cpu_din  = 8'h00;
      cpu_rd   = 1'b0;
      cpu_wr   = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (rom_addr !== 18'h00000) begin n_bad++; $display("FAIL reset_rom_addr: got %h expected 00000", rom_addr); end
      n_cmp++; if (cpu_dout !== 8'hFF) begin n_bad++; $display("FAIL reset_dout: got %h expected ff", cpu_dout); end
      n_cmp++; if (cpu_dvalid !== 1'b0) begin n_bad++; $display("FAIL reset_dvalid: got %b expected 0", cpu_dvalid); end
      n_cmp++; if (rom_bank !== 5'd1) begin n_bad++; $display("FAIL reset_rom_bank: got %h expected 01", rom_bank); end
      n_cmp++; if (ram_en !== 1'b0) begin n_bad++; $display("FAIL reset_ram_en: got %b expected 0", ram_en); end
      n_cmp++; if (bank_mode !== 1'b0) begin n_bad++; $display("FAIL reset_mode: got %b expected 0", bank_mode); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   typedef struct packed {
      logic        do_wr;
      logic [15:0] wa;
      logic [7:0]  wd;
      logic [15:0] ra;
      logic [17:0] exp_ra;
      logic [4:0]  exp_bank;
      logic        exp_mode;
   } map_t;

   // Optional register write, then a read issued in the very next cycle,
   // checked for address, bank status and 2-cycle data timing.
   task automatic test_bank_map;
      map_t tbl [12] = '{
         '{1'b0, 16'h0000, 8'h00, 16'h4000, 18'h04000, 5'h01, 1'b0},
         '{1'b1, 16'h2000, 8'h05, 16'h4123, 18'h14123, 5'h05, 1'b0},
         '{1'b1, 16'h2000, 8'h00, 16'h4000, 18'h04000, 5'h01, 1'b0},
         '{1'b1, 16'h3FFF, 8'h20, 16'h5000, 18'h05000, 5'h01, 1'b0},
         '{1'b1, 16'h2000, 8'h21, 16'h4001, 18'h04001, 5'h01, 1'b0},
         '{1'b1, 16'h2000, 8'h13, 16'h7FFF, 18'h0FFFF, 5'h13, 1'b0},
         '{1'b1, 16'h2000, 8'h01, 16'h3FFF, 18'h03FFF, 5'h01, 1'b0},
         '{1'b1, 16'h4000, 8'h01, 16'h4000, 18'h04000, 5'h01, 1'b0},
         '{1'b1, 16'h6000, 8'h01, 16'h0010, 18'h00010, 5'h01, 1'b1},
         '{1'b1, 16'h2000, 8'h0E, 16'h6ABC, 18'h3AABC, 5'h0E, 1'b1},
         '{1'b1, 16'h6000, 8'h00, 16'h0ABC, 18'h00ABC, 5'h0E, 1'b0},
         '{1'b1, 16'h5FFF, 8'h03, 16'h4000, 18'h38000, 5'h0E, 1'b0}
      };
      foreach (tbl[i]) begin
         if (tbl[i].do_wr) bus(tbl[i].wa, tbl[i].wd, 1'b0, 1'b1);
         bus(tbl[i].ra, 8'h00, 1'b1, 1'b0);
         n_cmp++; if (rom_addr !== tbl[i].exp_ra) begin n_bad++; $display("FAIL map%0d_rom_addr: got %h expected %h", i, rom_addr, tbl[i].exp_ra); end
         n_cmp++; if (rom_bank !== tbl[i].exp_bank) begin n_bad++; $display("FAIL map%0d_rom_bank: got %h expected %h", i, rom_bank, tbl[i].exp_bank); end
         n_cmp++; if (bank_mode !== tbl[i].exp_mode) begin n_bad++; $display("FAIL map%0d_mode: got %b expected %b", i, bank_mode, tbl[i].exp_mode); end
         n_cmp++; if (cpu_dvalid !== 1'b0) begin n_bad++; $display("FAIL map%0d_early_dvalid: got %b expected 0", i, cpu_dvalid); end
         @(negedge clk);
         n_cmp++; if (cpu_dvalid !== 1'b1) begin n_bad++; $display("FAIL map%0d_dvalid: got %b expected 1", i, cpu_dvalid); end
         n_cmp++; if (cpu_dout !== rom_byte(tbl[i].exp_ra)) begin n_bad++; $display("FAIL map%0d_dout: got %h expected %h", i, cpu_dout, rom_byte(tbl[i].exp_ra)); end
         @(negedge clk);
         n_cmp++; if (cpu_dvalid !== 1'b0) begin n_bad++; $display("FAIL map%0d_late_dvalid: got %b expected 0", i, cpu_dvalid); end
      end
   endtask

   // Four reads in consecutive cycles. The state entering this test is
   // bank_lo=0x0E, bank_hi=3, mode 0, so the switchable ROM bank is 0xE.
   task automatic test_back_to_back;
      logic [15:0] ra  [4] = '{16'h0000, 16'h4000, 16'h8000, 16'h0001};
      logic [7:0]  exd [4];
      exd[0] = rom_byte(18'h00000);
      exd[1] = rom_byte(18'h38000);
      exd[2] = 8'hFF;
      exd[3] = rom_byte(18'h00001);
      cpu_addr = ra[0];
      cpu_rd   = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k >= 1 && k <= 4) begin
            n_cmp++; if (cpu_dvalid !== 1'b1) begin n_bad++; $display("FAIL b2b%0d_dvalid: got %b expected 1", k - 1, cpu_dvalid); end
            n_cmp++; if (cpu_dout !== exd[k - 1]) begin n_bad++; $display("FAIL b2b%0d_dout: got %h expected %h", k - 1, cpu_dout, exd[k - 1]); end
         end else begin
            n_cmp++; if (cpu_dvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle%0d_dvalid: got %b expected 0", k, cpu_dvalid); end
         end
         if (k + 1 < 4) cpu_addr = ra[k + 1];
         else           cpu_rd   = 1'b0;
      end
      n_cmp++; if (rom_addr !== 18'h00001) begin n_bad++; $display("FAIL b2b_rom_addr: got %h expected 00001", rom_addr); end
   endtask

   // Read plus write in one cycle, ignored high writes, and an unmapped read.
   task automatic test_rd_wr_same;
      bus(16'h2000, 8'h03, 1'b1, 1'b1);
      n_cmp++; if (rom_bank !== 5'h03) begin n_bad++; $display("FAIL rdwr_rom_bank: got %h expected 03", rom_bank); end
      n_cmp++; if (rom_addr !== 18'h00001) begin n_bad++; $display("FAIL rdwr_rom_addr: got %h expected 00001", rom_addr); end
      repeat (3) begin
         n_cmp++; if (cpu_dvalid !== 1'b0) begin n_bad++; $display("FAIL rdwr_dvalid: got %b expected 0", cpu_dvalid); end
         @(negedge clk);
      end
      bus(16'hE000, 8'h00, 1'b0, 1'b1);
      bus(16'hC123, 8'h1F, 1'b0, 1'b1);
      n_cmp++; if (rom_bank !== 5'h03) begin n_bad++; $display("FAIL hi_write_rom_bank: got %h expected 03", rom_bank); end
      bus(16'hC000, 8'h00, 1'b1, 1'b0);
      n_cmp++; if (rom_addr !== 18'h00001) begin n_bad++; $display("FAIL unmapped_rom_addr: got %h expected 00001", rom_addr); end
      @(negedge clk);
      n_cmp++; if (cpu_dvalid !== 1'b1) begin n_bad++; $display("FAIL unmapped_dvalid: got %b expected 1", cpu_dvalid); end
      n_cmp++; if (cpu_dout !== 8'hFF) begin n_bad++; $display("FAIL unmapped_dout: got %h expected ff", cpu_dout); end
      @(negedge clk);
   endtask

   typedef struct packed {
      logic        is_rd;
      logic [15:0] addr;
      logic [7:0]  data;
      logic        exp_ram_en;
   } op_t;

   // RAM enable register plus the cartridge RAM window. A read op's data
   // field holds the expected byte.
   task automatic test_cart_ram;
`ifdef CART_RAM_EN
      op_t ops [13] = '{
         '{1'b0, 16'h0000, 8'h0A, 1'b1},
         '{1'b0, 16'hA005, 8'h5A, 1'b1},
         '{1'b1, 16'hA005, 8'h5A, 1'b1},
         '{1'b0, 16'h6000, 8'h01, 1'b1},
         '{1'b0, 16'hA005, 8'hC3, 1'b1},
         '{1'b1, 16'hA005, 8'hC3, 1'b1},
         '{1'b0, 16'h6000, 8'h00, 1'b1},
         '{1'b1, 16'hA005, 8'h5A, 1'b1},
         '{1'b0, 16'h0000, 8'h00, 1'b0},
         '{1'b0, 16'hA005, 8'h77, 1'b0},
         '{1'b1, 16'hA005, 8'hFF, 1'b0},
         '{1'b0, 16'h1FFF, 8'h1A, 1'b1},
         '{1'b1, 16'hA005, 8'h5A, 1'b1}
      };
`else
      op_t ops [6] = '{
         '{1'b0, 16'h0000, 8'h0A, 1'b1},
         '{1'b0, 16'hA005, 8'h5A, 1'b1},
         '{1'b1, 16'hA005, 8'hFF, 1'b1},
         '{1'b0, 16'h0000, 8'h0B, 1'b0},
         '{1'b1, 16'hA005, 8'hFF, 1'b0},
         '{1'b0, 16'h1FFF, 8'h1A, 1'b1}
      };
`endif
      foreach (ops[i]) begin
         if (!ops[i].is_rd) begin
            bus(ops[i].addr, ops[i].data, 1'b0, 1'b1);
         end else begin
            bus(ops[i].addr, 8'h00, 1'b1, 1'b0);
            @(negedge clk);
            n_cmp++; if (cpu_dvalid !== 1'b1) begin n_bad++; $display("FAIL ram%0d_dvalid: got %b expected 1", i, cpu_dvalid); end
            n_cmp++; if (cpu_dout !== ops[i].data) begin n_bad++; $display("FAIL ram%0d_dout: got %h expected %h", i, cpu_dout, ops[i].data); end
         end
         n_cmp++; if (ram_en !== ops[i].exp_ram_en) begin n_bad++; $display("FAIL ram%0d_ram_en: got %b expected %b", i, ram_en, ops[i].exp_ram_en); end
      end
      @(negedge clk);
   endtask

   // Reset arrives while one read sits in stage 1 and a second is on the bus.
   task automatic test_reset_midflight;
      bus(16'h6000, 8'h01, 1'b0, 1'b1);
      bus(16'h4000, 8'h00, 1'b1, 1'b0);
      cpu_addr = 16'h0002;
      cpu_rd   = 1'b1;
      #3 rst = 1'b1;
      #1;
      n_cmp++; if (rom_addr !== 18'h00000) begin n_bad++; $display("FAIL rstmid_rom_addr: got %h expected 00000", rom_addr); end
      n_cmp++; if (rom_bank !== 5'd1) begin n_bad++; $display("FAIL rstmid_rom_bank: got %h expected 01", rom_bank); end
      n_cmp++; if (bank_mode !== 1'b0) begin n_bad++; $display("FAIL rstmid_mode: got %b expected 0", bank_mode); end
      n_cmp++; if (ram_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_ram_en: got %b expected 0", ram_en); end
      n_cmp++; if (cpu_dout !== 8'hFF) begin n_bad++; $display("FAIL rstmid_dout: got %h expected ff", cpu_dout); end
      @(negedge clk);
      cpu_rd = 1'b0;
      rst    = 1'b0;
      repeat (3) begin
         n_cmp++; if (cpu_dvalid !== 1'b0) begin n_bad++; $display("FAIL rstmid_dvalid: got %b expected 0", cpu_dvalid); end
         @(negedge clk);
      end
      bus(16'h4000, 8'h00, 1'b1, 1'b0);
      n_cmp++; if (rom_addr !== 18'h04000) begin n_bad++; $display("FAIL post_rst_rom_addr: got %h expected 04000", rom_addr); end
      @(negedge clk);
      n_cmp++; if (cpu_dout !== rom_byte(18'h04000)) begin n_bad++; $display("FAIL post_rst_dout: got %h expected %h", cpu_dout, rom_byte(18'h04000)); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_bank_map();
      test_back_to_back();
      test_rd_wr_same();
      test_cart_ram();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Upper bound on simulation time so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cart_mbc1_ctrl.md
Name: cart_mbc1_ctrl

Overview:
- MBC1-style memory bank controller between the Game Boy CPU bus and the 256 KB cartridge ROM (four 64 KB synchronous ROM macros, 1-clock read latency, selected by address[17:16]).
- Decodes CPU writes to 0x0000-0x7FFF into bank/mode registers and translates CPU reads into an 18-bit ROM address.
- Runs a fully pipelined 2-cycle read path back to the CPU.
- Optionally hosts banked cartridge RAM.

Parameters:
- ROM_BANK_BITS, 4, number of 16 KB ROM bank bits actually decoded (256 KB = 16 banks); upper bank bits are masked off.
- UNMAPPED_DATA, 8'hFF, value returned for reads outside mapped ranges.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- cpu_addr  input  16  CPU byte address.
- cpu_din  input  8  CPU write data.
- cpu_wr  input  1  write strobe, one access per cycle high.
- cpu_rd  input  1  read strobe, one access per cycle high.
- cpu_dout  output  8  read data, valid when cpu_dvalid=1.
- cpu_dvalid  output  1  read-data valid pulse.
- rom_addr  output  18  registered address to the cartridge ROM.
- rom_q  input  8  ROM read data, 1 clock after rom_addr.
- rom_bank  output  5  current effective switchable bank (debug/status).
- ram_en  output  1  RAM-enable register state.
- bank_mode  output  1  MBC1 mode register state.

Behaviour:
- Reset (async, rst=1): bank_lo=5'd1, bank_hi=2'd0, mode=0, ram_en=0, rom_addr=0, cpu_dout=UNMAPPED_DATA, cpu_dvalid=0, pipeline valid bits cleared. Reset mid-read discards in-flight reads; no dvalid is produced for them.
- Register writes (cpu_wr=1, cpu_addr[15]=0), effective from the next cycle:
  - 0x0000-0x1FFF: ram_en = (cpu_din[3:0]==4'hA).
  - 0x2000-0x3FFF: bank_lo = cpu_din[4:0]; a written value of 0 is stored as 1. Writing 0x20 stores 1. Writing 0x21 stores 1.
  - 0x4000-0x5FFF: bank_hi = cpu_din[1:0].
  - 0x6000-0x7FFF: mode = cpu_din[0].
- Effective banks:
  - Switchable bank = {bank_hi, bank_lo}.
  - Fixed bank = mode ? {bank_hi, 5'b0} : 0.
  - Both are masked to ROM_BANK_BITS.
  - rom_bank = switchable bank before masking, low 5 bits.
- Address map for reads:
  - 0x0000-0x3FFF: rom_addr = {fixed_bank, cpu_addr[13:0]}.
  - 0x4000-0x7FFF: rom_addr = {switchable_bank, cpu_addr[13:0]}.
  - 0xA000-0xBFFF: cartridge RAM, feature dependent.
  - Any other address: returns UNMAPPED_DATA.
- Read pipeline, latency exactly 2:
  - Cycle N, cpu_rd=1: at edge N the controller registers rom_addr and the source select (ROM/RAM/unmapped), and sets stage-1 valid.
  - Edge N+1: the ROM presents rom_q, and stage-2 valid and select are registered.
  - During cycle N+2 (the cycle after edge N+1), cpu_dout carries the selected data and cpu_dvalid=1 for exactly one cycle.
  - Back-to-back reads are accepted every cycle, giving one dvalid per read in issue order.
- rom_addr holds its last value when no ROM read is issued.
- cpu_rd and cpu_wr high in the same cycle: the write executes, the read is dropped, and no dvalid is produced.
- A bank write at cycle N followed by a read at N+1 uses the new bank.
- Writes to 0x8000-0xFFFF other than RAM are ignored.

Optional Feature:
- CART_RAM_EN defined:
  - Instantiates 32 KB inferred synchronous cartridge RAM (4 × 8 KB banks).
  - RAM bank = mode ? bank_hi : 0.
  - Writes to 0xA000-0xBFFF with ram_en=1 store cpu_din.
  - Reads with ram_en=1 return RAM data with the same 2-cycle latency.
  - ram_en=0: writes are ignored and reads return UNMAPPED_DATA.
- CART_RAM_EN undefined:
  - No storage is instantiated.
  - 0xA000-0xBFFF reads return UNMAPPED_DATA and writes are ignored.
  - The ram_en register and port still function.

Test Plan:
- Reset, then read 0x4000 -> rom_addr=18'h04000, dvalid 2 cycles after rd, rom_bank=1.
- Write 0x2000←0x05, read 0x4123 -> rom_addr=18'h14123. Write 0x2000←0x00 -> rom_bank=1. Write 0x2000←0x13, read 0x7FFF -> rom_addr=18'h0FFFF (bank 0x13 masked to 3).
- Mode test: write 0x4000←0x01 and 0x6000←0x01, read 0x0010 -> rom_addr=18'h00010 (fixed bank 0x20 masked to 0). rom_bank=0x01, bank_mode=1.
- Four back-to-back reads of 0x0000, 0x4000, 0x8000, 0x0001 -> four consecutive dvalid pulses in order, the third =8'hFF.
- rd+wr same cycle to 0x2000 (din=0x03) -> no dvalid, rom_bank=3. Assert rst while 2 reads are in flight -> no dvalid, outputs at reset values.
- With CART_RAM_EN: write 0x0000←0x0A, write 0xA005←0x5A, read 0xA005 -> 0x5A. Write 0x0000←0x00, read 0xA005 -> 0xFF.
